hex_display_sched: RTL and testbench
====================================

HEX_DISPLAY_SCHED -- requirements
Module: hex_display_sched

Interface
REQ-001 The block SHALL have parameter DWELL, default 50000000, giving the number of clk cycles each source is shown in rotation (minimum 2).
REQ-002 The block SHALL have parameter BLINK_HALF, default 12500000, giving the half-period in clk cycles of the pin-mode blink (minimum 1).
REQ-003 The block SHALL have input clk, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have input rst_n, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have input req, 4 bits: req[i] high means source i wants display time.
REQ-006 The block SHALL have input vals, 4x24 bits: vals[i] is the hex value offered by source i.
REQ-007 The block SHALL have input pin_en, 1 bit: force display of one source regardless of req.
REQ-008 The block SHALL have input pin_sel, 2 bits: the source shown while pin_en is high.
REQ-009 The block SHALL have output value, 24 bits: registered value for the six-digit hex display.
REQ-010 The block SHALL have output debug_en, 1 bit: registered display enable; 0 blanks all digits.
REQ-011 The block SHALL have output src, 2 bits: index of the source currently granted.
REQ-012 The block SHALL have output ack, 4 bits: one-cycle pulse on ack[i] when source i is newly granted.

Function
REQ-013 The block SHALL implement the states IDLE, SHOW and PIN.
REQ-014 In IDLE, debug_en SHALL be 0, value SHALL hold, and no ack SHALL be asserted.
REQ-015 IDLE SHALL go to PIN when pin_en=1; otherwise it SHALL go to SHOW when req!=0, granting the lowest set req index.
REQ-016 In SHOW, debug_en SHALL be 1 and value SHALL load vals[src] every cycle, so value lags the input by exactly one cycle.
REQ-017 In SHOW, a dwell counter SHALL count from 0 to DWELL-1; at expiry the block SHALL grant the next set req index searching round-robin from src+1, wrapping 3->0.
REQ-018 If at dwell expiry only the current source is requesting, src SHALL stay, the counter SHALL reload and no ack SHALL be asserted.
REQ-019 If req[src] drops in SHOW, the next requester SHALL be granted on the following cycle with a fresh dwell; if req==0, the block SHALL go to IDLE.
REQ-020 A rising edge of req[0] while in SHOW with src!=0 SHALL preempt: src=0 on the next cycle, dwell restarted, ack[0] pulsed.
REQ-021 Every change of granted source in SHOW, including entry from IDLE, SHALL pulse ack[new src] for exactly one cycle, coincident with the src update.
REQ-022 pin_en=1 SHALL move SHOW or IDLE to PIN on the next cycle; PIN has priority over preemption and dwell expiry occurring in the same cycle.
REQ-023 In PIN, src SHALL follow pin_sel each cycle, value SHALL load vals[pin_sel] regardless of req, and ack SHALL stay 0.
REQ-024 On pin_en falling, the block SHALL go to SHOW granting pin_sel if req[pin_sel]=1, else the round-robin next requester, else IDLE; the dwell SHALL restart and ack SHALL pulse on a SHOW grant.

Reset
REQ-025 While rst_n=0 at a clk edge, the state SHALL become IDLE, value=0, debug_en=0, src=0, ack=0, and the dwell and blink counters SHALL be 0; reset mid-dwell or mid-pin SHALL abandon it.
REQ-026 The first cycle after reset release SHALL evaluate REQ-015 normally.

Configuration
REQ-027 With macro HEX_SCHED_BLINK_EN defined, debug_en in PIN SHALL start at 1 on PIN entry and toggle every BLINK_HALF cycles.
REQ-028 Without HEX_SCHED_BLINK_EN, debug_en in PIN SHALL be constantly 1 and no blink counter SHALL be built.

Verification
REQ-029 With DWELL=4, req=4'b0110: reset release -> ack[1] pulses, src=1 for 4 cycles, then src=2 with ack[2], then src=1 again.
REQ-030 With req=4'b0100 held: src stays 2 across several dwell expiries with no further ack pulses; vals[2]=24'h123456 -> value=24'h123456 one cycle later.
REQ-031 In SHOW with src=2 mid-dwell, raise req[0] -> next cycle src=0, ack[0]=1, fresh 4-cycle dwell.
REQ-032 pin_en=1, pin_sel=3, req=0, vals[3]=24'hABCDEF -> PIN, value=24'hABCDEF, ack=0; drop pin_en -> IDLE, debug_en=0.
REQ-033 With HEX_SCHED_BLINK_EN and BLINK_HALF=2, in PIN -> debug_en reads 1,1,0,0,1,...; without the macro -> debug_en stays 1.
REQ-034 Assert rst_n=0 mid-dwell in SHOW -> next edge value=0, debug_en=0, src=0, ack=0, state IDLE.

Source files
------------

// File: rtl/hex_display_sched.sv
// Round-robin scheduler that picks one of four 24-bit sources for a six-digit hex display.
// Define HEX_SCHED_BLINK_EN to make the display blink while a source is pinned.
module hex_display_sched #(
    parameter int DWELL      = 50000000,
    parameter int BLINK_HALF = 12500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [3:0][23:0] vals,
    input  logic             pin_en,
    input  logic [1:0]       pin_sel,
    output logic [23:0]      value,
    output logic             debug_en,
    output logic [1:0]       src,
    output logic [3:0]       ack
);

    localparam int DW = $clog2(DWELL);

    typedef enum logic [1:0] {IDLE, SHOW, PIN} state_t;

    state_t        state_reg;
    logic [DW-1:0] dwell_reg;
    logic          req0_prev_reg;

    logic          go_pin;
    logic          go_idle;
    logic          grant_en;
    logic [1:0]    grant_idx;
    logic [1:0]    rr_src;
    logic [1:0]    rr_pin;
    logic [1:0]    lowest;
    logic          preempt;
    logic          dwell_done;

    generate
        if (DWELL < 2) begin : g_bad_dwell
            $error("DWELL must be at least 2");
        end
        if (BLINK_HALF < 1) begin : g_bad_blink
            $error("BLINK_HALF must be at least 1");
        end
    endgenerate

`ifdef HEX_SCHED_BLINK_EN
    localparam int BW = $clog2(BLINK_HALF + 1);
    logic [BW-1:0] blink_reg;
`endif

    // First set request strictly after base, wrapping; base itself is checked last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] idx;
        logic       found;
        rr_pick = base;
        found   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = base + 2'(k);
            if (r[idx] && !found) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign rr_src     = rr_pick(req, src);
    assign rr_pin     = rr_pick(req, pin_sel);
    assign lowest     = rr_pick(req, 2'd3);
    assign preempt    = req[0] && !req0_prev_reg && (src != 2'd0);
    assign dwell_done = (dwell_reg == DW'(DWELL - 1));

    always_comb begin
        go_pin    = 1'b0;
        go_idle   = 1'b0;
        grant_en  = 1'b0;
        grant_idx = lowest;
        case (state_reg)
            IDLE: begin
                if (pin_en) begin
                    go_pin = 1'b1;
                end else if (req != 4'd0) begin
                    grant_en  = 1'b1;
                    grant_idx = lowest;
                end
            end
            SHOW: begin
                if (pin_en) begin
                    go_pin = 1'b1;
                end else if (req == 4'd0) begin
                    go_idle = 1'b1;
                end else if (preempt) begin
                    grant_en  = 1'b1;
                    grant_idx = 2'd0;
                end else if (!req[src] || (dwell_done && rr_src != src)) begin
                    grant_en  = 1'b1;
                    grant_idx = rr_src;
                end
            end
            PIN: begin
                if (!pin_en) begin
                    if (req[pin_sel]) begin
                        grant_en  = 1'b1;
                        grant_idx = pin_sel;
                    end else if (req != 4'd0) begin
                        grant_en  = 1'b1;
                        grant_idx = rr_pin;
                    end else begin
                        go_idle = 1'b1;
                    end
                end
            end
            default: go_idle = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            value         <= '0;
            debug_en      <= 1'b0;
            src           <= 2'd0;
            ack           <= 4'd0;
            dwell_reg     <= '0;
            req0_prev_reg <= 1'b0;
`ifdef HEX_SCHED_BLINK_EN
            blink_reg     <= '0;
`endif
        end else begin
            req0_prev_reg <= req[0];
            ack           <= 4'd0;
            if (go_pin) begin
                state_reg <= PIN;
                src       <= pin_sel;
                value     <= vals[pin_sel];
                debug_en  <= 1'b1;
                dwell_reg <= '0;
`ifdef HEX_SCHED_BLINK_EN
                blink_reg <= '0;
`endif
            end else if (grant_en) begin
                state_reg <= SHOW;
                src       <= grant_idx;
                value     <= vals[grant_idx];
                debug_en  <= 1'b1;
                ack       <= 4'b0001 << grant_idx;
                dwell_reg <= '0;
            end else if (go_idle) begin
                state_reg <= IDLE;
                debug_en  <= 1'b0;
            end else begin
                case (state_reg)
                    SHOW: begin
                        value     <= vals[src];
                        debug_en  <= 1'b1;
                        // Expiry with no other requester simply reloads the dwell.
                        dwell_reg <= dwell_done ? '0 : dwell_reg + 1'b1;
                    end
                    PIN: begin
                        src   <= pin_sel;
                        value <= vals[pin_sel];
`ifdef HEX_SCHED_BLINK_EN
                        if (blink_reg == BW'(BLINK_HALF - 1)) begin
                            blink_reg <= '0;
                            debug_en  <= !debug_en;
                        end else begin
                            blink_reg <= blink_reg + 1'b1;
                        end
`else
                        debug_en <= 1'b1;
`endif
                    end
                    default: debug_en <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hex_display_sched.sv
// Scoreboard bench for hex_display_sched: stimulus queues per-cycle expectations,
// a monitor pops and compares them against the outputs on the falling edge.
module tb_hex_display_sched;

    localparam logic [23:0] V0  = 24'h111111;
    localparam logic [23:0] V1  = 24'h222222;
    localparam logic [23:0] V2  = 24'h123456;
    localparam logic [23:0] V2B = 24'h654321;
    localparam logic [23:0] V3  = 24'hABCDEF;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       req;
    logic [3:0][23:0] vals;
    logic             pin_en;
    logic [1:0]       pin_sel;
    logic [23:0]      value;
    logic             debug_en;
    logic [1:0]       src;
    logic [3:0]       ack;

    typedef struct {
        int          cyc;
        logic [1:0]  src;
        logic [23:0] value;
        logic        den;
        logic [3:0]  ack;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic done = 1'b0;

    hex_display_sched #(.DWELL(4), .BLINK_HALF(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .vals     (vals),
        .pin_en   (pin_en),
        .pin_sel  (pin_sel),
        .value    (value),
        .debug_en (debug_en),
        .src      (src),
        .ack      (ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected debug_en k cycles after entering PIN.
    function automatic logic den_pin(input int k);
`ifdef HEX_SCHED_BLINK_EN
        return ((k / 2) % 2) == 0;
`else
        return k >= 0;
`endif
    endfunction

    task automatic step(input logic [1:0] e_src, input logic [23:0] e_val,
                        input logic e_den, input logic [3:0] e_ack);
        exp_t e;
        e.cyc   = cyc + 1;
        e.src   = e_src;
        e.value = e_val;
        e.den   = e_den;
        e.ack   = e_ack;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int c, input logic [23:0] act, input logic [23:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, c, act, want);
        end
    endtask

    // Monitor: compare every queued expectation against the outputs of its cycle.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                if (e.cyc < cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL stale_expectation cyc=%0d got=%0d want=%0d", cyc, cyc, e.cyc);
                end else begin
                    $display("txn cyc=%0d src=%0d value=%h debug_en=%0b ack=%b", cyc, src, value, debug_en, ack);
                    chk("src", cyc, 24'(src), 24'(e.src));
                    chk("value", cyc, value, e.value);
                    chk("debug_en", cyc, 24'(debug_en), 24'(e.den));
                    chk("ack", cyc, 24'(ack), 24'(e.ack));
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL unconsumed_expectations got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout want=completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        req     = 4'd0;
        pin_en  = 1'b0;
        pin_sel = 2'd0;
        vals[0] = V0;
        vals[1] = V1;
        vals[2] = V2;
        vals[3] = V3;

        // Reset, then release with two requesters: 1 and 2 alternate every 4 cycles.
        step(2'd0, 24'd0, 1'b0, 4'd0);
        req = 4'b0110;
        step(2'd0, 24'd0, 1'b0, 4'd0);
        rst_n = 1'b1;
        step(2'd1, V1, 1'b1, 4'b0010);
        repeat (3) step(2'd1, V1, 1'b1, 4'd0);
        step(2'd2, V2, 1'b1, 4'b0100);
        repeat (3) step(2'd2, V2, 1'b1, 4'd0);
        step(2'd1, V1, 1'b1, 4'b0010);

        // Current source drops; sole requester 2 holds across expiries.
        req = 4'b0100;
        step(2'd2, V2, 1'b1, 4'b0100);
        repeat (4) step(2'd2, V2, 1'b1, 4'd0);
        vals[2] = V2B;
        step(2'd2, V2B, 1'b1, 4'd0);
        repeat (5) step(2'd2, V2B, 1'b1, 4'd0);

        // Mid-dwell preemption by req[0], with a fresh dwell afterwards.
        req = 4'b0101;
        step(2'd0, V0, 1'b1, 4'b0001);
        repeat (3) step(2'd0, V0, 1'b1, 4'd0);
        step(2'd2, V2B, 1'b1, 4'b0100);

        // Pin source 3 with no requests, then release to IDLE.
        pin_en = 1'b1; pin_sel = 2'd3; req = 4'd0;
        step(2'd3, V3, den_pin(0), 4'd0);
        for (int k = 1; k <= 5; k++) step(2'd3, V3, den_pin(k), 4'd0);
        pin_en = 1'b0;
        step(2'd3, V3, 1'b0, 4'd0);
        step(2'd3, V3, 1'b0, 4'd0);

        // Pin from IDLE, follow pin_sel, release to round-robin next requester.
        req = 4'b0100; pin_en = 1'b1; pin_sel = 2'd0;
        step(2'd0, V0, den_pin(0), 4'd0);
        pin_sel = 2'd1;
        step(2'd1, V1, den_pin(1), 4'd0);
        pin_en = 1'b0;
        step(2'd2, V2B, 1'b1, 4'b0100);

        // Pin the shown source; release regrants it with an ack.
        req = 4'b0110; pin_en = 1'b1; pin_sel = 2'd2;
        step(2'd2, V2B, den_pin(0), 4'd0);
        pin_en = 1'b0;
        step(2'd2, V2B, 1'b1, 4'b0100);

        // Reset mid-dwell, then normal evaluation on release; req==0 goes IDLE.
        step(2'd2, V2B, 1'b1, 4'd0);
        rst_n = 1'b0;
        step(2'd0, 24'd0, 1'b0, 4'd0);
        rst_n = 1'b1;
        step(2'd1, V1, 1'b1, 4'b0010);
        req = 4'd0;
        step(2'd1, V1, 1'b0, 4'd0);

        // Round-robin wrap 3 -> 0.
        req = 4'b1001;
        step(2'd0, V0, 1'b1, 4'b0001);
        repeat (3) step(2'd0, V0, 1'b1, 4'd0);
        step(2'd3, V3, 1'b1, 4'b1000);
        repeat (3) step(2'd3, V3, 1'b1, 4'd0);
        step(2'd0, V0, 1'b1, 4'b0001);
        req = 4'd0;
        step(2'd0, V0, 1'b0, 4'd0);

        repeat (2) @(posedge clk);
        done = 1'b1;
    end

endmodule
